instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Registered, buffered instruction-decode stage for the Simple RISC Machine.
//  Accepts 16-bit instructions over a valid/ready handshake into a DEPTH-entry queue.
//  Holds the head instruction in an output register and decodes it into FSM/datapath fields.
//  Sign-extends immediates to DATA_W and muxes register numbers by one-hot nsel.
//  Sits between instruction fetch/memory and the controller FSM plus datapath.
// PARAMETERS
//  DATA_W  16  datapath width; sximm5/sximm8 sign-extended to this width (>=16)
//  DEPTH   4   queue entries ahead of output register (power of 2, >=2)
// PORTS
//  clk        in   1         rising-edge clock
//  reset_n    in   1         asynchronous active-low reset
//  in_valid   in   1         in_instr valid
//  in_ready   out  1         stage can accept this cycle
//  in_instr   in   16        encoded instruction
//  flush      in   1         discard all held instructions (branch taken)
//  out_valid  out  1         decoded fields valid
//  out_ready  in   1         FSM consumes current instruction
//  nsel       in   3         one-hot reg select: 100=Rn, 010=Rd, 001=Rm
//  opcode     out  3         instr[15:13]
//  op         out  2         instr[12:11]
//  ALUop      out  2         instr[12:11]
//  shift      out  2         instr[4:3]
//  b_cond     out  3         instr[10:8]
//  sximm5     out  DATA_W    sign-extended instr[4:0]
//  sximm8     out  DATA_W    sign-extended instr[7:0]
//  readnum    out  3         nsel-selected register number
//  writenum   out  3         equals readnum
//  nsel_err   out  1         sticky: non-one-hot nsel seen while out_valid
//  count      out  CNT_W     instructions held (queue + output reg), CNT_W=$clog2(DEPTH+2)
// BEHAVIOUR
//  Reset (async, reset_n=0): queue empty, output reg empty, out_valid=0, nsel_err=0, count=0.
//  in_ready = !queue_full && !flush; registered-only, no combinational path from out_ready.
//  Accept: in_valid && in_ready at an edge. Pop: out_valid && out_ready at an edge.
//  Output reg load: when empty or popped, loads queue head; if queue empty, loads in_instr (bypass).
//  Latency: instruction accepted at edge N is out_valid after edge N when queue empty.
//  Simultaneous accept+pop with empty queue: new instr goes straight to output reg; count unchanged.
//  Ordering is strict FIFO; no drop or duplicate except on flush.
//  Queue full (DEPTH entries): in_ready=0; in_valid ignored. A pop the same cycle frees a slot next cycle.
//  Pointer wrap-around: DEPTH power of 2; pointers wrap modulo DEPTH.
//  flush=1 at an edge: queue and output reg emptied, count=0, nsel_err cleared.
//  Flush dominates a same-cycle accept and pop.
//  Decoded fields are combinational from the output reg.
//  When out_valid=0, all fields force 0, including readnum/writenum.
//  sximm*: upper bits replicate bit 4 (imm5) or bit 7 (imm8) up to DATA_W.
//  nsel not one-hot: readnum=writenum=0; nsel_err sets at edge if out_valid; sticky until reset/flush.
//  Reset mid-operation: contents lost immediately; outputs go to reset values asynchronously.
// STRUCTURE
//  Package rsm_decode_pkg holds the following shared definitions:
//   field positions: OPC_MSB=15, OP_LSB=11, RN_LSB=8, RD_LSB=5, SH_LSB=3;
//   NSEL_RN=3'b100, NSEL_RD=3'b010, NSEL_RM=3'b001.
//  Sub-module decode_fifo #(16,DEPTH) provides push/pop/full/empty/count.
//  Top level holds the output reg, bypass mux, field decode, nsel mux and nsel_err.
// TESTING
//  1. Reset release, push 16'hD0A5 when empty -> next cycle out_valid=1, opcode=3'b110, op=2'b10.
//     Same case, continued: b_cond=3'd0, sximm8=16'hFFA5, sximm5=16'h0005, shift=2'b00.
//  2. out_ready=0, push 5 instrs (DEPTH=4) -> first in output reg, then in_ready=0 with count=5.
//     Then pulse out_ready -> outputs shown in push order, in_ready reasserts after 1 cycle.
//  3. Streaming: in_valid=out_ready=1 for 20 cycles with an incrementing imm8 -> all 20 emitted in order.
//     Same case, continued: count stays 1 and there are no bubbles.
//  4. Instr 16'hA1E7 with nsel = 100/010/001 -> readnum 1/7/7.
//     Same instr with nsel=011 -> readnum 0 and nsel_err=1, held; flush -> nsel_err=0.
//  5. Queue holds 3 plus the output reg; flush with same-cycle in_valid -> next cycle out_valid=0, count=0.
//     After the flush the dropped instr never emerges.
//  6. DATA_W=32, instr imm8=8'h80 -> sximm8=32'hFFFFFF80.
//     reset_n low mid-stream -> outputs zero before the next clk edge.

Source files
------------

// File: rtl/rsm_decode_pkg.sv
// Shared instruction field positions, register-select encodings and helpers for the
// Simple RISC Machine decode stage.
package rsm_decode_pkg;
   localparam int OPC_MSB = 15;
   localparam int OP_LSB  = 11;
   localparam int RN_LSB  = 8;
   localparam int RD_LSB  = 5;
   localparam int SH_LSB  = 3;

   localparam logic [2:0] NSEL_RN = 3'b100;
   localparam logic [2:0] NSEL_RD = 3'b010;
   localparam logic [2:0] NSEL_RM = 3'b001;

   typedef logic [15:0] instr_t;

   function automatic logic is_onehot3(input logic [2:0] sel);
      return (sel == NSEL_RN) || (sel == NSEL_RD) || (sel == NSEL_RM);
   endfunction
endpackage

// File: rtl/instr_decode_stage_if.sv
// Upstream handshake, downstream handshake and decoded-field bundle of the decode stage.
// The stage uses the slave view; the fetch side and controller FSM use the master view.
interface instr_decode_stage_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 2);

   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_instr;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        nsel;
   logic [2:0]        opcode;
   logic [1:0]        op;
   logic [1:0]        ALUop;
   logic [1:0]        shift;
   logic [2:0]        b_cond;
   logic [DATA_W-1:0] sximm5;
   logic [DATA_W-1:0] sximm8;
   logic [2:0]        readnum;
   logic [2:0]        writenum;
   logic              nsel_err;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  in_valid, in_instr, flush, out_ready, nsel,
      output in_ready, out_valid, opcode, op, ALUop, shift, b_cond,
             sximm5, sximm8, readnum, writenum, nsel_err, count
   );

   modport master (
      output in_valid, in_instr, flush, out_ready, nsel,
      input  in_ready, out_valid, opcode, op, ALUop, shift, b_cond,
             sximm5, sximm8, readnum, writenum, nsel_err, count
   );
endinterface

// File: rtl/decode_fifo.sv
// Circular instruction queue with a combinational head read so the output register
// can load the oldest entry in the same cycle it is popped.
module decode_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush_i,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               data_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               head_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;

   // Storage carries no reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i)
         mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
endmodule

// File: rtl/instr_decode_stage.sv
// Buffered decode stage: queue + output register with empty-queue bypass, combinational
// field decode, nsel register mux and a sticky illegal-nsel flag.
module instr_decode_stage
   import rsm_decode_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   instr_decode_stage_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH + 2);
   localparam int FCW   = $clog2(DEPTH + 1);

   instr_t           out_instr_q, out_instr_d;
   logic             out_valid_q, out_valid_d;
   logic             nsel_err_q;
   instr_t           fifo_head;
   logic             fifo_full, fifo_empty;
   logic [FCW-1:0]   fifo_count;
   logic             in_ready, accept, pop, load, bypass, fifo_push, fifo_pop;
   logic [2:0]       regnum;

   decode_fifo #(16, DEPTH) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .flush_i (bus.flush),
      .push_i  (fifo_push),
      .data_i  (bus.in_instr),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // in_ready depends only on held state and flush, never on out_ready.
   assign in_ready = !fifo_full && !bus.flush;

   always_comb begin
      accept      = bus.in_valid && in_ready;
      pop         = out_valid_q && bus.out_ready;
      load        = !out_valid_q || pop;
      fifo_pop    = load && !fifo_empty;
      bypass      = load && fifo_empty && accept;
      fifo_push   = accept && !bypass;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      if (load) begin
         out_valid_d = !fifo_empty || accept;
         out_instr_d = fifo_empty ? bus.in_instr : fifo_head;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         nsel_err_q  <= 1'b0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         nsel_err_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         if (out_valid_q && !is_onehot3(bus.nsel))
            nsel_err_q <= 1'b1;
      end
   end

   always_comb begin
      bus.opcode = '0;
      bus.op     = '0;
      bus.ALUop  = '0;
      bus.shift  = '0;
      bus.b_cond = '0;
      bus.sximm5 = '0;
      bus.sximm8 = '0;
      regnum     = '0;
      if (out_valid_q) begin
         bus.opcode = out_instr_q[OPC_MSB -: 3];
         bus.op     = out_instr_q[OP_LSB +: 2];
         bus.ALUop  = out_instr_q[OP_LSB +: 2];
         bus.shift  = out_instr_q[SH_LSB +: 2];
         bus.b_cond = out_instr_q[RN_LSB +: 3];
         bus.sximm5 = {{(DATA_W-5){out_instr_q[4]}}, out_instr_q[4:0]};
         bus.sximm8 = {{(DATA_W-8){out_instr_q[7]}}, out_instr_q[7:0]};
         case (bus.nsel)
            NSEL_RN: regnum = out_instr_q[RN_LSB +: 3];
            NSEL_RD: regnum = out_instr_q[RD_LSB +: 3];
            NSEL_RM: regnum = out_instr_q[2:0];
            default: regnum = '0;
         endcase
      end
   end

   assign bus.readnum   = regnum;
   assign bus.writenum  = regnum;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.nsel_err  = nsel_err_q;
   assign bus.count     = CNT_W'(fifo_count) + CNT_W'(out_valid_q);
endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized + directed bench for instr_decode_stage: a negedge monitor scores every cycle
// against a queue-based reference of accepted-but-unconsumed instructions.
module tb_instr_decode_stage;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   instr_decode_stage_if #(.DATA_W(16), .DEPTH(DEPTH)) bus ();
   instr_decode_stage_if #(.DATA_W(32), .DEPTH(DEPTH)) if32 ();

   instr_decode_stage #(.DATA_W(16), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   instr_decode_stage #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if32)
   );

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   bit err_m  = 1'b0;
   logic [15:0] mq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Two's-complement sign extension of a bits-wide value to w bits, by arithmetic.
   function automatic logic [63:0] sext(input int unsigned v, input int bits, input int w);
      if (v >= (32'd1 << (bits - 1)))
         return (64'd1 << w) - (64'd1 << bits) + 64'(v);
      return 64'(v);
   endfunction

   function automatic int unsigned pick_reg(input logic [15:0] ins, input logic [2:0] sel);
      int unsigned i = int'(ins);
      case (sel)
         3'b100:  return (i >> 8) & 7;
         3'b010:  return (i >> 5) & 7;
         3'b001:  return i & 7;
         default: return 0;
      endcase
   endfunction

   // Monitor: compare DUT against the reference queue, then advance the reference.
   always @(negedge clk) begin
      if (mon_en) begin
         int sz;
         bit v, onehot, popped, accepted;
         int unsigned h;
         sz = mq.size();
         v  = (sz > 0);
         h  = v ? int'(mq[0]) : 0;
         chk("out_valid", 64'(bus.out_valid), 64'(v));
         chk("count", 64'(bus.count), 64'(sz));
         chk("in_ready", 64'(bus.in_ready), 64'((sz < DEPTH + 1) && !bus.flush));
         chk("nsel_err", 64'(bus.nsel_err), 64'(err_m));
         chk("opcode", 64'(bus.opcode), 64'((h >> 13) & 7));
         chk("op", 64'(bus.op), 64'((h >> 11) & 3));
         chk("ALUop", 64'(bus.ALUop), 64'((h >> 11) & 3));
         chk("shift", 64'(bus.shift), 64'((h >> 3) & 3));
         chk("b_cond", 64'(bus.b_cond), 64'((h >> 8) & 7));
         chk("sximm5", 64'(bus.sximm5), v ? sext(h & 31, 5, 16) : 64'd0);
         chk("sximm8", 64'(bus.sximm8), v ? sext(h & 255, 8, 16) : 64'd0);
         chk("readnum", 64'(bus.readnum), v ? 64'(pick_reg(mq[0], bus.nsel)) : 64'd0);
         chk("writenum", 64'(bus.writenum), v ? 64'(pick_reg(mq[0], bus.nsel)) : 64'd0);
         onehot = (bus.nsel == 3'b100) || (bus.nsel == 3'b010) || (bus.nsel == 3'b001);
         if (bus.flush) begin
            mq.delete();
            err_m = 1'b0;
         end else begin
            popped   = v && bus.out_ready;
            accepted = bus.in_valid && (sz < DEPTH + 1);
            if (v && !onehot)
               err_m = 1'b1;
            if (popped) begin
               $display("POP  instr=%04h count=%0d", mq[0], sz);
               void'(mq.pop_front());
            end
            if (accepted)
               mq.push_back(bus.in_instr);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      bus.nsel      = 3'b100;
   endtask

   task automatic drain();
      int n = 0;
      idle_inputs();
      bus.out_ready = 1'b1;
      while (mq.size() != 0 && n < 40) begin
         step();
         n++;
      end
      chk("drain_empty", 64'(mq.size()), 64'd0);
      bus.out_ready = 1'b0;
      step();
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      if32.in_valid  = 1'b0;
      if32.in_instr  = '0;
      if32.flush     = 1'b0;
      if32.out_ready = 1'b0;
      if32.nsel      = 3'b100;
      #3;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_nsel_err", 64'(bus.nsel_err), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Empty-queue bypass: visible one edge after acceptance.
      step();
      bus.in_valid = 1'b1;
      bus.in_instr = 16'hD0A5;
      step();
      bus.in_valid = 1'b0;
      chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
      chk("t1_opcode", 64'(bus.opcode), 64'h6);
      chk("t1_op", 64'(bus.op), 64'h2);
      chk("t1_b_cond", 64'(bus.b_cond), 64'h0);
      chk("t1_sximm8", 64'(bus.sximm8), 64'hFFA5);
      chk("t1_sximm5", 64'(bus.sximm5), 64'h0005);
      chk("t1_shift", 64'(bus.shift), 64'h0);
      drain();

      // Fill queue + output register, then a single consume reopens the input.
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 16'($urandom);
         step();
      end
      bus.in_instr = 16'h1234;
      chk("t2_count_full", 64'(bus.count), 64'd5);
      chk("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("t2_in_ready_back", 64'(bus.in_ready), 64'd1);
      chk("t2_count_after", 64'(bus.count), 64'd4);
      drain();

      // Back-to-back streaming with incrementing imm8.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 16'h6000 | 16'(i);
         step();
         if (i > 0)
            chk("t3_stream_count", 64'(bus.count), 64'd1);
      end
      drain();

      // nsel mux and sticky error.
      bus.in_valid = 1'b1;
      bus.in_instr = 16'hA1E7;
      step();
      bus.in_valid = 1'b0;
      chk("t4_rn", 64'(bus.readnum), 64'd1);
      bus.nsel = 3'b010;
      #1 chk("t4_rd", 64'(bus.readnum), 64'd7);
      bus.nsel = 3'b001;
      #1 chk("t4_rm", 64'(bus.writenum), 64'd7);
      bus.nsel = 3'b011;
      #1 chk("t4_bad_readnum", 64'(bus.readnum), 64'd0);
      step();
      chk("t4_err_set", 64'(bus.nsel_err), 64'd1);
      bus.nsel = 3'b100;
      step();
      chk("t4_err_held", 64'(bus.nsel_err), 64'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("t4_err_flushed", 64'(bus.nsel_err), 64'd0);

      // Flush with a held queue and a same-cycle input.
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 16'h0100 + 16'(i);
         step();
      end
      bus.in_instr = 16'hBEEF;
      bus.flush    = 1'b1;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
      chk("t5_count", 64'(bus.count), 64'd0);
      bus.out_ready = 1'b1;
      repeat (3) step();
      chk("t5_no_ghost", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b0;

      // Wide datapath sign extension.
      if32.in_valid = 1'b1;
      if32.in_instr = 16'h0080;
      step();
      if32.in_valid = 1'b0;
      chk("t6_sximm8_32", 64'(if32.sximm8), 64'hFFFF_FF80);
      chk("t6_sximm5_32", 64'(if32.sximm5), 64'h0);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_instr  = 16'($urandom);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 15))
            0:       bus.nsel = 3'($urandom);
            1, 2, 3: bus.nsel = 3'b010;
            4, 5, 6: bus.nsel = 3'b001;
            default: bus.nsel = 3'b100;
         endcase
         step();
      end
      drain();

      // Asynchronous reset in the middle of a cycle with content held.
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = 16'($urandom);
         step();
      end
      bus.in_valid = 1'b0;
      bus.nsel     = 3'b111;
      step();
      #2;
      reset_n = 1'b0;
      mon_en  = 1'b0;
      #1;
      chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
      chk("ar_count", 64'(bus.count), 64'd0);
      chk("ar_nsel_err", 64'(bus.nsel_err), 64'd0);
      chk("ar_sximm8", 64'(bus.sximm8), 64'd0);
      chk("ar_readnum", 64'(bus.readnum), 64'd0);
      chk("ar_out_valid_32", 64'(if32.out_valid), 64'd0);
      mq.delete();
      err_m = 1'b0;
      idle_inputs();
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      mon_en  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = 16'h4321;
      step();
      drain();

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end
endmodule
